issue_bru_fifo: RTL
===================

// Module: issue_bru_fifo
// PURPOSE
//  Decoupling queue between the issue stage and execute_bru: buffers issued branch/jump ops
//  (issue_execute_pack_t) and presents the oldest entry to the BRU with a valid flag.
//  Consumes the BRU pop strobe; empties on commit flush. Circular buffer, FWFT read.
// PARAMETERS
//  DEPTH  4  entries; power of two, >= 2
// PORTS
//  clk                             in   1     clock; all state updates on rising edge
//  rst                             in   1     synchronous reset, active-high
//  issue_bru_fifo_data_in          in   pack  issue_execute_pack_t from issue stage
//  issue_bru_fifo_push             in   1     write request from issue
//  issue_bru_fifo_full             out  1     no free entry; issue must not count on push
//  issue_bru_fifo_data_out         out  pack  oldest entry (issue_execute_pack_t)
//  issue_bru_fifo_data_out_valid   out  1     data_out holds a real entry
//  issue_bru_fifo_pop              in   1     BRU consumed data_out this cycle
//  issue_bru_fifo_flush            in   1     commit flush (commit_feedback_pack.enable && .flush)
//  issue_bru_fifo_count            out  CW    occupancy, CW = $clog2(DEPTH)+1
// BEHAVIOUR
//  - Reset: rptr=wptr=0, count=0, full=0, data_out_valid=0. Storage is not reset;
//    data_out is don't-care while valid=0.
//  - Pointers: $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    empty = (rptr==wptr); full = index bits equal and wrap bits differ.
//    Increment wraps naturally modulo 2*DEPTH.
//  - push_acc = push && !full. Accepted data is written at wptr[idx] and wptr increments.
//    A push while full is dropped; a simulation assertion fires.
//    A pop in the same cycle does not free space for a push while full.
//  - pop_acc = pop && data_out_valid; rptr increments. A pop while empty is ignored.
//  - Read is combinational: data_out = mem[rptr[idx]]; valid = !empty.
//    An entry written at edge N is visible at cycle N+1 (latency 1).
//  - Simultaneous push_acc and pop_acc: count is unchanged and both pointers advance.
//  - Flush has highest priority: at the next edge rptr=wptr=0 and count=0.
//    A push or pop in the flush cycle is discarded and has no effect.
//  - count = wptr - rptr (CW-bit modular subtraction); outputs from registered pointers only.
//  - Reset asserted mid-operation behaves exactly like flush and also clears the pointers.
// CONFIGURATION
//  ISSUE_BRU_FIFO_BYPASS_EN defined:
//    - When empty and push=1 (no flush), data_out = data_in and data_out_valid=1 in the same cycle.
//    - If pop=1 in that cycle, the entry is consumed and not written: pointers and count unchanged.
//    - If pop=0, the entry is written normally.
//  Not defined:
//    - Strict 1-cycle latency; data_out_valid depends only on registered state.
//    - No combinational path from push/data_in to the outputs.
// STRUCTURE
//  - issue_execute_pack_t comes from common.svh; no new typedefs.
//  - DEPTH default lives as a `define in config.svh (`ISSUE_BRU_FIFO_DEPTH).
//  - Sub-module fifo_ptr_ctrl (DEPTH param) owns the pointers, full/empty/count and the
//    flush/reset priority. This module adds the storage array and bypass muxing.
// TESTING  (DEPTH=4)
//  1. Reset, then 4 pushes with pc=0x100,0x104,0x108,0x10C and no pop
//     -> full=1, count=4; 5th push dropped; pops return 0x100..0x10C in order;
//        then valid=0, count=0.
//  2. Wrap: push/pop streaming 10 entries, count held at 2
//     -> order preserved across the pointer wrap; full never 1.
//  3. Full plus simultaneous push and pop -> pop accepted, push dropped, count 4->3.
//  4. 3 entries queued, flush with push=1 and pop=1
//     -> next cycle count=0, valid=0; pushed entry never appears.
//  5. Pop while empty -> no pointer change and count stays 0.
//     Reset asserted at count=3 -> next cycle count=0.
//  6. BYPASS_EN on, empty, push(pc=0x200)+pop same cycle
//     -> data_out.pc=0x200, valid=1 that cycle; count stays 0.
//     Off: valid=0 that cycle, pc=0x200 appears next cycle, count=1.

Source files
------------

// File: rtl/issue_bru_fifo_pkg.sv
// Shared types and defaults for the issue->BRU decoupling FIFO.
// Build option: ISSUE_BRU_FIFO_BYPASS_EN enables same-cycle empty-queue bypass.
`ifndef ISSUE_BRU_FIFO_DEPTH
`define ISSUE_BRU_FIFO_DEPTH 4
`endif

package issue_bru_fifo_pkg;

   localparam int ISSUE_BRU_FIFO_DEPTH_P = `ISSUE_BRU_FIFO_DEPTH;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic [5:0]  rob_idx;
      logic [3:0]  br_op;
   } issue_execute_pack_t;

endpackage

// File: rtl/issue_bru_fifo_if.sv
// Issue/BRU side bundle of the FIFO; master = issue+BRU+commit, slave = FIFO.
import issue_bru_fifo_pkg::*;

interface issue_bru_fifo_if #(
   parameter int DEPTH = ISSUE_BRU_FIFO_DEPTH_P
);
   localparam int CW = $clog2(DEPTH) + 1;

   issue_execute_pack_t issue_bru_fifo_data_in;
   logic                issue_bru_fifo_push;
   logic                issue_bru_fifo_full;
   issue_execute_pack_t issue_bru_fifo_data_out;
   logic                issue_bru_fifo_data_out_valid;
   logic                issue_bru_fifo_pop;
   logic                issue_bru_fifo_flush;
   logic [CW-1:0]       issue_bru_fifo_count;

   modport master (
      output issue_bru_fifo_data_in, issue_bru_fifo_push, issue_bru_fifo_pop,
             issue_bru_fifo_flush,
      input  issue_bru_fifo_full, issue_bru_fifo_data_out,
             issue_bru_fifo_data_out_valid, issue_bru_fifo_count
   );

   modport slave (
      input  issue_bru_fifo_data_in, issue_bru_fifo_push, issue_bru_fifo_pop,
             issue_bru_fifo_flush,
      output issue_bru_fifo_full, issue_bru_fifo_data_out,
             issue_bru_fifo_data_out_valid, issue_bru_fifo_count
   );
endinterface

// File: rtl/issue_bru_fifo_chk.sv
// Simulation-only checks for the issue->BRU FIFO.
module issue_bru_fifo_chk (
   input logic clk,
   input logic rst,
   input logic flush,
   input logic push,
   input logic full
);
   // Flags issue pushes that arrive while no slot is free (the op is dropped).
   always @(posedge clk) begin
      if (!rst && !flush && push) begin
         assert (!full) else $warning("issue_bru_fifo: push dropped while full");
      end
   end
endmodule

// File: rtl/issue_bru_fifo_ptr_ctrl.sv
// Pointer control: wrap-bit pointers, full/empty/count, flush and reset priority.
import issue_bru_fifo_pkg::*;

module issue_bru_fifo_ptr_ctrl #(
   parameter  int DEPTH = ISSUE_BRU_FIFO_DEPTH_P,
   localparam int PW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   output logic [PW-1:0] rptr,
   output logic [PW-1:0] wptr,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] count,
   output logic          push_acc
);
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0] rptr_r;
   logic [PW-1:0] wptr_r;
   logic          pop_acc_s;

   // Status and acceptance decode; a pop never frees space for a same-cycle push.
   always_comb begin
      empty     = (rptr_r == wptr_r);
      full      = (rptr_r[PW-2:0] == wptr_r[PW-2:0]) && (rptr_r[PW-1] != wptr_r[PW-1]);
      count     = wptr_r - rptr_r;
      push_acc  = 1'b0;
      pop_acc_s = 1'b0;
      if (!rst && !flush) begin
         push_acc  = push && !full;
         pop_acc_s = pop && !empty;
      end else begin
         push_acc  = 1'b0;
         pop_acc_s = 1'b0;
      end
   end

   // Pointer state; reset and flush both return the queue to empty at index 0.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rptr_r <= PTR_ZERO;
         wptr_r <= PTR_ZERO;
      end else begin
         if (push_acc) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (pop_acc_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
      end
   end

   assign rptr = rptr_r;
   assign wptr = wptr_r;
endmodule

// File: rtl/issue_bru_fifo.sv
// Issue->BRU decoupling FIFO: circular buffer with first-word-fall-through read.
// Build option: ISSUE_BRU_FIFO_BYPASS_EN forwards data_in when the queue is empty.
import issue_bru_fifo_pkg::*;

module issue_bru_fifo #(
   parameter int DEPTH = ISSUE_BRU_FIFO_DEPTH_P
) (
   input logic              clk,
   input logic              rst,
   issue_bru_fifo_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   issue_execute_pack_t mem_r [DEPTH];
   logic                push_req_s;
   logic                pop_req_s;
   logic                push_acc_s;
   logic [PW-1:0]       rptr_s;
   logic [PW-1:0]       wptr_s;
   logic                full_s;
   logic                empty_s;
   logic [PW-1:0]       count_s;

   // Request gating; a bypassed op that is popped at once never enters the queue.
   always_comb begin
      push_req_s = bus.issue_bru_fifo_push;
      pop_req_s  = bus.issue_bru_fifo_pop && !empty_s;
`ifdef ISSUE_BRU_FIFO_BYPASS_EN
      if (empty_s && bus.issue_bru_fifo_push && bus.issue_bru_fifo_pop) begin
         push_req_s = 1'b0;
      end else begin
         push_req_s = bus.issue_bru_fifo_push;
      end
`endif
   end

   issue_bru_fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.issue_bru_fifo_flush),
      .push     (push_req_s),
      .pop      (pop_req_s),
      .rptr     (rptr_s),
      .wptr     (wptr_s),
      .full     (full_s),
      .empty    (empty_s),
      .count    (count_s),
      .push_acc (push_acc_s)
   );

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_acc_s) begin
         mem_r[wptr_s[IW-1:0]] <= bus.issue_bru_fifo_data_in;
      end
   end

   // Head presentation.
   always_comb begin
      bus.issue_bru_fifo_data_out       = mem_r[rptr_s[IW-1:0]];
      bus.issue_bru_fifo_data_out_valid = !empty_s;
`ifdef ISSUE_BRU_FIFO_BYPASS_EN
      if (empty_s && bus.issue_bru_fifo_push && !bus.issue_bru_fifo_flush && !rst) begin
         bus.issue_bru_fifo_data_out       = bus.issue_bru_fifo_data_in;
         bus.issue_bru_fifo_data_out_valid = 1'b1;
      end else begin
         bus.issue_bru_fifo_data_out       = mem_r[rptr_s[IW-1:0]];
         bus.issue_bru_fifo_data_out_valid = !empty_s;
      end
`endif
   end

   assign bus.issue_bru_fifo_full  = full_s;
   assign bus.issue_bru_fifo_count = count_s;

   issue_bru_fifo_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.issue_bru_fifo_flush),
      .push  (bus.issue_bru_fifo_push),
      .full  (full_s)
   );
endmodule
